// File: rtl/mem_access_sequencer.sv
// Multi-cycle sequencer for one decoded SPARC V8 load/store: drives MAR, MDR, RAM and
// register-file controls, waits on the RAM MFC handshake, and issues two word beats for
// LDD/STD. Aborts with a trap on illegal op3, misalignment or MFC timeout.
module mem_access_sequencer #(
  parameter int unsigned MFC_TIMEOUT = 15
) (
  input  logic       Clk,
  input  logic       RESET,
  input  logic       start,
  input  logic [5:0] op3,
  input  logic [4:0] rd,
  input  logic [2:0] addr_lo,
  input  logic       MFC,
  output logic       busy,
  output logic       done,
  output logic       trap,
  output logic [1:0] trap_code,
  output logic       MAR_Enable,
  output logic       RAM_enable,
  output logic [5:0] RAM_OpCode,
  output logic       MDR_Enable,
  output logic       MDR_Mux_select,
  output logic       register_file,
  output logic [4:0] in_PC,
  output logic [4:0] in_PA,
  output logic       word_sel
);

  localparam logic [7:0] CntLast        = 8'(MFC_TIMEOUT - 1);
  localparam logic [1:0] CodeMisaligned = 2'b01;
  localparam logic [1:0] CodeIllegal    = 2'b10;
  localparam logic [1:0] CodeTimeout    = 2'b11;

  typedef enum logic [3:0] {
    StIdle, StAddr, StSdata, StMem, StCap, StWb, StNext, StDone, StTrap
  } state_e;

  state_e     state_q, state_d;
  logic       beat_q, beat_d;
  logic [5:0] op3_q, op3_d;
  logic [4:0] rd_q, rd_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] code_q, code_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       trap_q, trap_d;
  logic [1:0] trap_code_q, trap_code_d;
  logic       mar_en_q, mar_en_d;
  logic       ram_en_q, ram_en_d;
  logic [5:0] ram_op_q, ram_op_d;
  logic       mdr_en_q, mdr_en_d;
  logic       mdr_sel_q, mdr_sel_d;
  logic       rf_we_q, rf_we_d;
  logic [4:0] in_pc_q, in_pc_d;
  logic [4:0] in_pa_q, in_pa_d;
  logic       word_sel_q, word_sel_d;

  logic in_legal, in_misaligned;
  logic cur_store, cur_double, last_beat;

  // Legality and alignment of the request presented with start.
  always_comb begin
    in_legal      = 1'b1;
    in_misaligned = 1'b0;
    case (op3)
      6'b000000, 6'b000100:            in_misaligned = (addr_lo[1:0] != 2'b00);
      6'b000010, 6'b001010, 6'b000110: in_misaligned = addr_lo[0];
      6'b000011, 6'b000111:            in_misaligned = (addr_lo != 3'b000) || rd[0];
      6'b000001, 6'b001001, 6'b000101: in_misaligned = 1'b0;
      default:                         in_legal      = 1'b0;
    endcase
  end

  // Properties of the latched access; all legal stores have op3[2] set.
  always_comb begin
    cur_store  = op3_q[2];
    cur_double = (op3_q[1:0] == 2'b11);
    last_beat  = !cur_double || beat_q;
  end

  // Next-state and latched-request logic.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    op3_d   = op3_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          op3_d  = op3;
          rd_d   = rd;
          beat_d = 1'b0;
          if (!in_legal) begin
            state_d = StTrap;
            code_d  = CodeIllegal;
          end else if (in_misaligned) begin
            state_d = StTrap;
            code_d  = CodeMisaligned;
          end else begin
            state_d = StAddr;
          end
        end
      end
      StAddr: begin
        state_d = cur_store ? StSdata : StMem;
        cnt_d   = '0;
      end
      StSdata: begin
        state_d = StMem;
        cnt_d   = '0;
      end
      StMem: begin
        // MFC takes priority over an expiring counter.
        if (MFC) begin
          state_d = cur_store ? StNext : StCap;
        end else if (cnt_q == CntLast) begin
          state_d = StTrap;
          code_d  = CodeTimeout;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StCap: state_d = StWb;
      // Loads resolve the beat decision in WB; stores spend a cycle in NEXT.
      StWb, StNext: begin
        if (last_beat) begin
          state_d = StDone;
        end else begin
          beat_d  = 1'b1;
          state_d = StAddr;
        end
      end
      StDone, StTrap: state_d = StIdle;
      default:        state_d = StIdle;
    endcase
  end

  logic       nxt_store, nxt_double;
  logic [4:0] nxt_reg;

  // Moore output decode from the next state, so the outputs can be registered.
  always_comb begin
    nxt_store   = op3_d[2];
    nxt_double  = (op3_d[1:0] == 2'b11);
    nxt_reg     = beat_d ? {rd_d[4:1], 1'b1} : rd_d;
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
    trap_d      = (state_d == StTrap);
    trap_code_d = (state_d == StTrap) ? code_d : 2'b00;
    mar_en_d    = (state_d == StAddr);
    ram_en_d    = (state_d == StMem);
    ram_op_d    = '0;
    if (state_d inside {StAddr, StSdata, StMem}) begin
      ram_op_d = nxt_double ? {3'b000, nxt_store, 2'b00} : op3_d;
    end
    mdr_en_d    = (state_d == StSdata) || (state_d == StCap);
    mdr_sel_d   = ((state_d == StMem) && !nxt_store) || (state_d == StCap);
    rf_we_d     = (state_d == StWb);
    in_pc_d     = (state_d == StWb) ? nxt_reg : 5'd0;
    in_pa_d     = (state_d == StSdata) ? nxt_reg : 5'd0;
    word_sel_d  = beat_d && (state_d inside {StAddr, StSdata, StMem, StCap, StWb, StNext});
  end

  // State, latched request and registered outputs.
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      beat_q      <= 1'b0;
      op3_q       <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      code_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      trap_q      <= 1'b0;
      trap_code_q <= '0;
      mar_en_q    <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_op_q    <= '0;
      mdr_en_q    <= 1'b0;
      mdr_sel_q   <= 1'b0;
      rf_we_q     <= 1'b0;
      in_pc_q     <= '0;
      in_pa_q     <= '0;
      word_sel_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      op3_q       <= op3_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      trap_q      <= trap_d;
      trap_code_q <= trap_code_d;
      mar_en_q    <= mar_en_d;
      ram_en_q    <= ram_en_d;
      ram_op_q    <= ram_op_d;
      mdr_en_q    <= mdr_en_d;
      mdr_sel_q   <= mdr_sel_d;
      rf_we_q     <= rf_we_d;
      in_pc_q     <= in_pc_d;
      in_pa_q     <= in_pa_d;
      word_sel_q  <= word_sel_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign trap           = trap_q;
  assign trap_code      = trap_code_q;
  assign MAR_Enable     = mar_en_q;
  assign RAM_enable     = ram_en_q;
  assign RAM_OpCode     = ram_op_q;
  assign MDR_Enable     = mdr_en_q;
  assign MDR_Mux_select = mdr_sel_q;
  assign register_file  = rf_we_q;
  assign in_PC          = in_pc_q;
  assign in_PA          = in_pa_q;
  assign word_sel       = word_sel_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: the driver predicts each access outcome from
// op3 size/alignment rules and MFC delays, a monitor pops and compares on done/trap.
module tb_mem_access_sequencer;

  localparam int T = 15;

  logic       Clk = 1'b0;
  logic       RESET = 1'b1;
  logic       start = 1'b0;
  logic [5:0] op3 = '0;
  logic [4:0] rd = '0;
  logic [2:0] addr_lo = '0;
  logic       MFC = 1'b0;
  logic       busy, done, trap, MAR_Enable, RAM_enable, MDR_Enable, MDR_Mux_select;
  logic       register_file, word_sel;
  logic [1:0] trap_code;
  logic [5:0] RAM_OpCode;
  logic [4:0] in_PC, in_PA;

  mem_access_sequencer #(.MFC_TIMEOUT(T)) dut (
    .Clk(Clk), .RESET(RESET), .start(start), .op3(op3), .rd(rd), .addr_lo(addr_lo),
    .MFC(MFC), .busy(busy), .done(done), .trap(trap), .trap_code(trap_code),
    .MAR_Enable(MAR_Enable), .RAM_enable(RAM_enable), .RAM_OpCode(RAM_OpCode),
    .MDR_Enable(MDR_Enable), .MDR_Mux_select(MDR_Mux_select),
    .register_file(register_file), .in_PC(in_PC), .in_PA(in_PA), .word_sel(word_sel)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic [25:0] out_vec;
  assign out_vec = {done, trap, trap_code, MAR_Enable, RAM_enable, RAM_OpCode, MDR_Enable,
                    MDR_Mux_select, register_file, in_PC, in_PA, word_sel};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit         is_trap;
    logic [1:0] code;
    int         start_cyc;
    int         end_cyc;
    int         n_mar;
    int         n_mem;
    int         n_ram;
    logic [5:0] ram_op;
    int         n_regs;
    logic [4:0] reg0;
    logic [4:0] reg1;
    int         mem_off;
  } exp_t;

  exp_t exp_q[$];
  int   m_beat[2];

  // Access size in bytes, 0 for an illegal op3.
  function automatic int op_size(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000100:            return 4;
      6'b000001, 6'b001001, 6'b000101: return 1;
      6'b000010, 6'b001010, 6'b000110: return 2;
      6'b000011, 6'b000111:            return 8;
      default:                         return 0;
    endcase
  endfunction

  function automatic bit op_is_store(input logic [5:0] op);
    return op inside {6'b000100, 6'b000101, 6'b000110, 6'b000111};
  endfunction

  // Reference model: outcome, timing and datapath activity of one access.
  function automatic exp_t predict(input logic [5:0] op, input logic [4:0] r,
                                   input logic [2:0] a, input int m0, input int m1,
                                   input int now);
    exp_t e;
    int sz, elapsed, m;
    bit st, stop;
    logic [4:0] rr;
    sz = op_size(op);
    st = op_is_store(op);
    e.is_trap = 0; e.code = 2'b00; e.start_cyc = now; e.n_mar = 0; e.n_mem = 0;
    e.n_ram = 0; e.n_regs = 0; e.reg0 = '0; e.reg1 = '0; e.mem_off = st ? 3 : 2;
    e.ram_op = (sz == 8) ? (st ? 6'b000100 : 6'b000000) : op;
    if (sz == 0) begin
      e.is_trap = 1; e.code = 2'b10; e.end_cyc = now + 1;
    end else if ((int'(a) % sz != 0) || (sz == 8 && r[0])) begin
      e.is_trap = 1; e.code = 2'b01; e.end_cyc = now + 1;
    end else begin
      elapsed = 0;
      stop = 0;
      for (int b = 0; b < ((sz == 8) ? 2 : 1); b++) begin
        if (!stop) begin
          m  = (b == 0) ? m0 : m1;
          rr = (b == 0) ? r : {r[4:1], 1'b1};
          e.n_mar++;
          e.n_mem++;
          if (st) begin
            if (e.n_regs == 0) e.reg0 = rr; else e.reg1 = rr;
            e.n_regs++;
          end
          if (m >= T) begin
            e.n_ram += T;
            e.is_trap = 1; e.code = 2'b11;
            e.end_cyc = now + elapsed + (st ? 3 : 2) + T;
            stop = 1;
          end else begin
            e.n_ram += m + 1;
            if (!st) begin
              if (e.n_regs == 0) e.reg0 = rr; else e.reg1 = rr;
              e.n_regs++;
            end
            elapsed += 4 + m;
          end
        end
      end
      if (!stop) e.end_cyc = now + elapsed + 1;
    end
    return e;
  endfunction

  // RAM model: answers MFC after m_beat[word_sel] cycles of RAM_enable; noise otherwise.
  int mem_cnt = 0;
  always @(posedge Clk) begin
    #1;
    if (RAM_enable) begin
      MFC = (mem_cnt == m_beat[word_sel]);
      mem_cnt++;
    end else begin
      MFC = 1'($urandom);
      mem_cnt = 0;
    end
  end

  // Monitor: accumulate datapath activity, compare against the scoreboard on done/trap.
  int         n_mar = 0, n_mem = 0, n_ram = 0, n_regs = 0, first_mar = 0, first_mem = 0;
  logic [5:0] o_op0 = '0, o_op1 = '0;
  logic       o_ws0 = 0, o_ws1 = 0, ram_prev = 0;
  logic [4:0] o_reg0 = '0, o_reg1 = '0;

  task automatic clear_acc();
    n_mar = 0; n_mem = 0; n_ram = 0; n_regs = 0; ram_prev = 0;
  endtask

  task automatic note_reg(input logic [4:0] r);
    if (n_regs == 0) o_reg0 = r; else if (n_regs == 1) o_reg1 = r;
    n_regs++;
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (RESET) begin
      clear_acc();
    end else begin
      if (!busy) check("idle_outputs_zero", 32'(out_vec), 32'd0);
      if (MAR_Enable) begin
        if (n_mar == 0) first_mar = cyc;
        n_mar++;
      end
      if (RAM_enable) begin
        n_ram++;
        if (!ram_prev) begin
          if (n_mem == 0) begin first_mem = cyc; o_op0 = RAM_OpCode; o_ws0 = word_sel; end
          if (n_mem == 1) begin o_op1 = RAM_OpCode; o_ws1 = word_sel; end
          n_mem++;
        end
      end
      ram_prev = RAM_enable;
      if (MDR_Enable && !MDR_Mux_select) note_reg(in_PA);
      if (register_file) note_reg(in_PC);
      if (done || trap) begin
        check("done_trap_exclusive", 32'(done & trap), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_end", 32'(done | trap), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("end_is_trap", 32'(trap), 32'(e.is_trap));
          check("trap_code", 32'(trap_code), e.is_trap ? 32'(e.code) : 32'd0);
          check("end_cycle", 32'(cyc), 32'(e.end_cyc));
          check("mar_pulses", 32'(n_mar), 32'(e.n_mar));
          check("mem_phases", 32'(n_mem), 32'(e.n_mem));
          check("ram_enable_cycles", 32'(n_ram), 32'(e.n_ram));
          check("reg_accesses", 32'(n_regs), 32'(e.n_regs));
          if (e.n_regs > 0) check("reg_addr_beat0", 32'(o_reg0), 32'(e.reg0));
          if (e.n_regs > 1) check("reg_addr_beat1", 32'(o_reg1), 32'(e.reg1));
          if (e.n_mem > 0) begin
            check("first_mar_cycle", 32'(first_mar), 32'(e.start_cyc + 1));
            check("first_mem_cycle", 32'(first_mem), 32'(e.start_cyc + e.mem_off));
            check("ram_opcode_beat0", 32'(o_op0), 32'(e.ram_op));
            check("word_sel_beat0", 32'(o_ws0), 32'd0);
          end
          if (e.n_mem > 1) begin
            check("ram_opcode_beat1", 32'(o_op1), 32'(e.ram_op));
            check("word_sel_beat1", 32'(o_ws1), 32'd1);
          end
        end
        clear_acc();
      end
    end
  end

  // Issue one access; optionally re-pulse start with junk while busy.
  task automatic issue(input logic [5:0] op, input logic [4:0] r, input logic [2:0] a,
                       input int m0, input int m1, input bit repulse);
    exp_t e;
    @(posedge Clk);
    #1;
    m_beat[0] = m0;
    m_beat[1] = m1;
    op3 = op; rd = r; addr_lo = a; start = 1'b1;
    e = predict(op, r, a, m0, m1, cyc);
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    start = 1'b0;
    op3 = 6'($urandom); rd = 5'($urandom); addr_lo = 3'($urandom);
    if (repulse && (e.end_cyc > e.start_cyc + 3)) begin
      @(posedge Clk);
      #1;
      start = 1'b1;
      op3 = 6'($urandom_range(0, 7)); rd = 5'($urandom); addr_lo = 3'b000;
      @(posedge Clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge Clk);
    while (busy && k < 100) begin
      @(negedge Clk);
      k++;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  function automatic int rand_m();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return int'($urandom_range(0, 3));
    if (r < 8) return T - 1;
    if (r == 8) return T;
    return 255;
  endfunction

  initial begin
    int k;
    logic [5:0] legal_ops [10];
    logic [5:0] op;
    legal_ops = '{6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b001001, 6'b001010,
                  6'b000100, 6'b000101, 6'b000110, 6'b000111};
    m_beat[0] = 0;
    m_beat[1] = 0;
    repeat (3) begin
      @(negedge Clk);
      check("reset_outputs", 32'({busy, out_vec}), 32'd0);
    end
    @(posedge Clk);
    #1;
    RESET = 1'b0;

    issue(6'b000000, 5'd5, 3'd0, 2, 0, 1'b0);   // LD, MFC after 2 cycles
    wait_idle();
    issue(6'b000111, 5'd6, 3'd0, 0, 0, 1'b1);   // STD, immediate MFC
    wait_idle();
    issue(6'b000010, 5'd4, 3'd1, 0, 0, 1'b0);   // LDUH misaligned
    wait_idle();
    issue(6'b000011, 5'd3, 3'd0, 0, 0, 1'b0);   // LDD odd rd
    wait_idle();
    issue(6'b001111, 5'd2, 3'd0, 0, 0, 1'b0);   // illegal op3
    wait_idle();
    issue(6'b000000, 5'd9, 3'd4, 255, 0, 1'b1); // load timeout
    wait_idle();
    issue(6'b000100, 5'd9, 3'd0, 255, 0, 1'b0); // store timeout
    wait_idle();
    issue(6'b000000, 5'd1, 3'd0, T - 1, 0, 1'b1); // MFC on the expiry cycle
    wait_idle();
    issue(6'b000011, 5'd10, 3'd0, 1, 255, 1'b1); // LDD, second beat times out
    wait_idle();

    // Reset while waiting on MFC: everything clears, no completion follows.
    issue(6'b000000, 5'd7, 3'd0, 255, 0, 1'b0);
    k = 0;
    while (!RAM_enable && k < 10) begin
      @(negedge Clk);
      k++;
    end
    check("reached_mem_before_reset", 32'(RAM_enable), 32'd1);
    @(posedge Clk);
    #1;
    RESET = 1'b1;
    #1;
    check("reset_abort_outputs", 32'({busy, out_vec}), 32'd0);
    exp_q.delete();
    @(posedge Clk);
    #1;
    RESET = 1'b0;
    repeat (20) @(negedge Clk);
    issue(6'b000001, 5'd12, 3'd3, 1, 0, 1'b0);
    wait_idle();

    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) != 0) op = legal_ops[$urandom_range(0, 9)];
      else op = 6'($urandom);
      issue(op, 5'($urandom), ($urandom_range(0, 1) == 1) ? 3'($urandom) : 3'd0,
            rand_m(), rand_m(), 1'($urandom));
      wait_idle();
    end

    repeat (3) @(negedge Clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
